// File: rtl/my_ws2812_rx.sv
// WS2812 single-wire receiver: times each high pulse, decodes 24-bit GRB pixels
// and forwards the bits meant for downstream pixels on dout.
module my_ws2812_rx #(
  parameter int CLK_SCALE = 1,
  parameter int T_MIN_HI  = 8 / CLK_SCALE,
  parameter int T_BIT     = 60 / CLK_SCALE,
  parameter int T_MAX_HI  = 110 / CLK_SCALE,
  parameter int T_RST     = 5000 / CLK_SCALE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic        dout,
  output logic [23:0] color,
  output logic        color_valid,
  output logic [5:0]  led_idx,
  output logic        frame_done,
  output logic        err,
  output logic        busy
);
  localparam int CW = $clog2(T_RST + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] MIN_HI_C = CW'(T_MIN_HI);
  localparam logic [CW-1:0] BIT_C    = CW'(T_BIT);
  localparam logic [CW-1:0] MAX_HI_C = CW'(T_MAX_HI);
  localparam logic [CW-1:0] RST_C    = CW'(T_RST);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HI, S_LO} state_t;

  state_t        state_q;
  logic          din_meta_q, din_s_q, din_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [22:0]   shift_q;
  logic [23:0]   shift_d, color_q;
  logic [4:0]    bit_cnt_q;
  logic [5:0]    led_idx_q;
  logic          fwd_q, dout_q, color_valid_q, frame_done_q, err_q;
  logic          rise, fall, bit_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_meta_q <= 1'b0;
      din_s_q    <= 1'b0;
      din_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      din_meta_q <= din;
      din_s_q    <= din_meta_q;
      din_prev_q <= din_s_q;
      cnt_q      <= cnt_d;
    end
  end

  assign rise = din_s_q & ~din_prev_q;
  assign fall = ~din_s_q & din_prev_q;

  // Run length at the current level, this cycle included; saturates so long idles stay valid.
  always_comb begin
    if (din_s_q != din_prev_q)
      cnt_d = CW'(1);
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CW'(1);
  end

  // On a falling edge cnt_q still holds the length of the high pulse just ended.
  assign bit_val = (cnt_q >= BIT_C);
  assign shift_d = {shift_q, bit_val};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_SYNC;
      shift_q       <= '0;
      color_q       <= '0;
      bit_cnt_q     <= '0;
      led_idx_q     <= '0;
      fwd_q         <= 1'b0;
      dout_q        <= 1'b0;
      color_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      color_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      dout_q        <= fwd_q & din_s_q;

      // Pixel bookkeeping lags the strobe by one cycle so the strobe carries the old index.
      if (color_valid_q) begin
        bit_cnt_q <= '0;
        led_idx_q <= led_idx_q + 6'd1;
        fwd_q     <= 1'b1;
      end

      case (state_q)
        S_SYNC: begin
          dout_q <= 1'b0;
          if (!din_s_q && cnt_d >= RST_C)
            state_q <= S_IDLE;
        end
        S_IDLE: begin
          dout_q <= 1'b0;
          if (rise) begin
            led_idx_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            fwd_q     <= 1'b0;
            state_q   <= S_HI;
          end
        end
        S_HI: begin
          if (fall) begin
            if (cnt_q < MIN_HI_C) begin
              err_q   <= 1'b1;
              fwd_q   <= 1'b0;
              dout_q  <= 1'b0;
              state_q <= S_SYNC;
            end else begin
              shift_q <= shift_d[22:0];
              if (bit_cnt_q == 5'd23) begin
                color_q       <= shift_d;
                color_valid_q <= 1'b1;
                bit_cnt_q     <= 5'd24;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
              state_q <= S_LO;
            end
          end else if (cnt_d >= MAX_HI_C) begin
            err_q   <= 1'b1;
            fwd_q   <= 1'b0;
            dout_q  <= 1'b0;
            state_q <= S_SYNC;
          end
        end
        S_LO: begin
          if (rise) begin
            state_q <= S_HI;
          end else if (cnt_d >= RST_C) begin
            frame_done_q <= 1'b1;
            err_q        <= (bit_cnt_q != 5'd0);
            fwd_q        <= 1'b0;
            dout_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

  assign dout        = dout_q;
  assign color       = color_q;
  assign color_valid = color_valid_q;
  assign led_idx     = led_idx_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;
  assign busy        = (state_q == S_HI) || (state_q == S_LO);

endmodule
